// File: rtl/micro_mult_core.sv
// Sequential 4x4 signed shift-and-add multiplier: a four-state controller sequencing
// operand, shift, accumulator and output registers; one product every 10 cycles.

module ControlUnit (
    input  logic clk,
    input  logic rst_n,
    input  logic flag,
    output logic enA,
    output logic enB,
    output logic enDPO,
    output logic ABsel,
    output logic sr_c1,
    output logic sr_c0,
    output logic enSR,
    output logic SRsel,
    output logic alu_c0,
    output logic alu_c1,
    output logic alu_c2,
    output logic enACC,
    output logic clrACC
);
    typedef enum logic [1:0] {S_LOAD, S_ADD, S_SHIFT, S_OUT} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_i;
    logic [1:0] w_i_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_i     <= '0;
        end else begin
            r_state <= w_next;
            r_i     <= w_i_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_i_next = r_i;
        enA      = 1'b0;
        enB      = 1'b0;
        enDPO    = 1'b0;
        ABsel    = 1'b0;
        sr_c1    = 1'b0;
        sr_c0    = 1'b0;
        enSR     = 1'b0;
        SRsel    = 1'b0;
        alu_c0   = 1'b0;
        alu_c1   = 1'b0;
        alu_c2   = 1'b0;
        enACC    = 1'b0;
        clrACC   = 1'b0;
        unique case (r_state)
            S_LOAD: begin
                enA      = 1'b1;
                enB      = 1'b1;
                clrACC   = 1'b1;
                w_i_next = '0;
                w_next   = S_ADD;
            end
            S_ADD: begin
                {sr_c1, sr_c0} = r_i;
                if (flag) begin
                    ABsel = 1'b1;
                    enACC = 1'b1;
                    // The last step carries the multiplier sign bit, so it subtracts.
                    if (r_i == 2'd3) alu_c1 = 1'b1;
                    else             alu_c0 = 1'b1;
                end
                w_next = S_SHIFT;
            end
            S_SHIFT: begin
                enSR     = 1'b1;
                SRsel    = 1'b1;
                w_i_next = r_i + 2'd1;
                w_next   = (r_i == 2'd3) ? S_OUT : S_ADD;
            end
            S_OUT: begin
                enDPO  = 1'b1;
                w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end
endmodule

module DataPath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       enA,
    input  logic       enB,
    input  logic       enDPO,
    input  logic       ABsel,
    input  logic       sr_c1,
    input  logic       sr_c0,
    input  logic       enSR,
    input  logic       SRsel,
    input  logic       alu_c0,
    input  logic       alu_c1,
    input  logic       alu_c2,
    input  logic       enACC,
    input  logic       clrACC,
    output logic       flag,
    output logic [7:0] o_out
);
    logic [3:0] r_M;
    logic [3:0] r_Q;
    logic [7:0] r_P;
    logic [7:0] r_OUT;
    logic [7:0] w_msext;
    logic [7:0] w_addend;
    logic [7:0] w_alu;
    logic [3:0] w_q_next;

    assign w_msext  = {{4{r_M[3]}}, r_M};
    assign w_addend = ABsel ? (w_msext << {sr_c1, sr_c0}) : '0;
    assign w_q_next = SRsel ? {1'b0, r_Q[3:1]} : i_b;
    assign flag     = r_Q[0];
    assign o_out    = r_OUT;

    always_comb begin
        w_alu = r_P;
        case ({alu_c2, alu_c1, alu_c0})
            3'b001:  w_alu = r_P + w_addend;
            3'b010:  w_alu = r_P - w_addend;
            default: w_alu = r_P;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_M   <= '0;
            r_Q   <= '0;
            r_P   <= '0;
            r_OUT <= '0;
        end else begin
            if (enA)
                r_M <= i_a;
            if ((enB && !SRsel) || (enSR && SRsel))
                r_Q <= w_q_next;
            if (clrACC)
                r_P <= '0;
            else if (enACC)
                r_P <= w_alu;
            if (enDPO)
                r_OUT <= r_P;
        end
    end
endmodule

module micro_mult_core (
    input  logic       sys_clk,
    input  logic       nsys_rst,
    input  logic [3:0] inputA,
    input  logic [3:0] inputB,
    output logic [7:0] SMP_out
);
    logic w_enA, w_enB, w_enDPO, w_ABsel, w_sr_c1, w_sr_c0, w_enSR, w_SRsel;
    logic w_alu_c0, w_alu_c1, w_alu_c2, w_enACC, w_clrACC, w_flag;

    ControlUnit u_ctrl (
        .clk    (sys_clk),
        .rst_n  (nsys_rst),
        .flag   (w_flag),
        .enA    (w_enA),
        .enB    (w_enB),
        .enDPO  (w_enDPO),
        .ABsel  (w_ABsel),
        .sr_c1  (w_sr_c1),
        .sr_c0  (w_sr_c0),
        .enSR   (w_enSR),
        .SRsel  (w_SRsel),
        .alu_c0 (w_alu_c0),
        .alu_c1 (w_alu_c1),
        .alu_c2 (w_alu_c2),
        .enACC  (w_enACC),
        .clrACC (w_clrACC)
    );

    DataPath u_dp (
        .clk    (sys_clk),
        .rst_n  (nsys_rst),
        .i_a    (inputA),
        .i_b    (inputB),
        .enA    (w_enA),
        .enB    (w_enB),
        .enDPO  (w_enDPO),
        .ABsel  (w_ABsel),
        .sr_c1  (w_sr_c1),
        .sr_c0  (w_sr_c0),
        .enSR   (w_enSR),
        .SRsel  (w_SRsel),
        .alu_c0 (w_alu_c0),
        .alu_c1 (w_alu_c1),
        .alu_c2 (w_alu_c2),
        .enACC  (w_enACC),
        .clrACC (w_clrACC),
        .flag   (w_flag),
        .o_out  (SMP_out)
    );
endmodule

// File: tb/tb_micro_mult_core.sv
// Self-checking bench for micro_mult_core: directed cases, mid-operation reset,
// operand scrambling and an exhaustive sweep against a signed-arithmetic model.

module tb_micro_mult_core;
    logic       sys_clk;
    logic       nsys_rst;
    logic [3:0] inputA;
    logic [3:0] inputB;
    logic [7:0] SMP_out;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0]  r_held;

    micro_mult_core dut (
        .sys_clk  (sys_clk),
        .nsys_rst (nsys_rst),
        .inputA   (inputA),
        .inputB   (inputB),
        .SMP_out  (SMP_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] ref_mult(input logic [3:0] a, input logic [3:0] b);
        int x;
        int y;
        int p;
        x = a[3] ? int'(a) - 16 : int'(a);
        y = b[3] ? int'(b) - 16 : int'(b);
        p = x * y;
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge so the next posedge is a LOAD edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit scramble,
                          input string tag);
        logic [7:0] exp;
        exp    = ref_mult(a, b);
        inputA = a;
        inputB = b;
        for (int k = 1; k <= 10; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (scramble && k < 10) begin
                inputA = 4'($urandom);
                inputB = 4'($urandom);
            end
            if (k < 10) check({tag, "_hold"}, SMP_out, r_held);
            else        check(tag, SMP_out, exp);
        end
        r_held = exp;
    endtask

    initial begin
        nsys_rst = 1'b0;
        inputA   = '0;
        inputB   = '0;
        r_held   = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset_value", SMP_out, 8'h00);
        nsys_rst = 1'b1;

        run_op(4'd3, 4'd5, 1'b0, "pos_3x5");
        run_op(4'd7, 4'd7, 1'b0, "pos_7x7");
        run_op(4'h8, 4'h8, 1'b0, "neg8xneg8");
        run_op(4'd7, 4'h8, 1'b0, "7xneg8");
        run_op(4'hF, 4'hF, 1'b0, "neg1xneg1");
        run_op(4'hF, 4'd7, 1'b0, "neg1x7");
        run_op(4'd0, 4'hF, 1'b0, "zero");
        run_op(4'd6, 4'hB, 1'b1, "scramble");
        run_op(4'd2, 4'd3, 1'b0, "b2b_first");
        run_op(4'hD, 4'd4, 1'b0, "b2b_second");

        // Abort an operation during its 5th cycle with an asynchronous reset.
        inputA = 4'd5;
        inputB = 4'd5;
        repeat (4) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
        end
        check("pre_abort_hold", SMP_out, r_held);
        #2 nsys_rst = 1'b0;
        #1 check("async_reset", SMP_out, 8'h00);
        @(negedge sys_clk);
        check("reset_held", SMP_out, 8'h00);
        nsys_rst = 1'b1;
        r_held   = '0;
        run_op(4'h9, 4'd6, 1'b0, "after_reset");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(4'(a), 4'(b), ((a + b) % 5) == 0, "sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
